// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle divider sequencing,
// branch flush priority, stall-cycle counter and sticky divider-timeout flag.
module hazard_stall_controller #(
   parameter int DIV_TIMEOUT = 40,
   parameter int CNT_W       = 6
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  ID_RS1_ADDR,
   input  logic [4:0]  ID_RS2_ADDR,
   input  logic        ID_USES_RS1,
   input  logic        ID_USES_RS2,
   input  logic        ID_IS_DIV,
   input  logic        EX_MEM_READ,
   input  logic        EX_WRITE_EN,
   input  logic [4:0]  EX_RD_ADDR,
   input  logic        BRANCH_TAKEN,
   input  logic        DIV_DONE,
   output logic        PC_STALL,
   output logic        IF_ID_STALL,
   output logic        IF_ID_FLUSH,
   output logic        ID_EX_BUBBLE,
   output logic        DIV_START,
   output logic        DIV_RESULT_SEL,
   output logic        DIV_ERROR,
   output logic [31:0] STALL_COUNT
);

   typedef enum logic [1:0] {
      RUN,
      DIV_WAIT,
      DIV_RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              div_error_q, div_error_d;
   logic [31:0]       stall_count_q, stall_count_d;
   logic              load_use;

   assign load_use = EX_MEM_READ & EX_WRITE_EN & (EX_RD_ADDR != 5'd0) &
                     ((ID_USES_RS1 & (ID_RS1_ADDR == EX_RD_ADDR)) |
                      (ID_USES_RS2 & (ID_RS2_ADDR == EX_RD_ADDR)));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         div_error_q   <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         div_error_q   <= div_error_d;
         stall_count_q <= stall_count_d;
      end
   end

   // A wrong-path branch or a pending load-use stall must not launch a divide.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_error_d = div_error_q;
      case (state_q)
         RUN: begin
            if (!BRANCH_TAKEN && !load_use && ID_IS_DIV) begin
               state_d = DIV_WAIT;
               cnt_d   = '0;
            end
         end
         DIV_WAIT: begin
            if (DIV_DONE) begin
               state_d = DIV_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               div_error_d = 1'b1;
               state_d     = DIV_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DIV_RELEASE: state_d = RUN;
         default:     state_d = RUN;
      endcase
      stall_count_d = stall_count_q;
      if (PC_STALL && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_comb begin
      PC_STALL       = 1'b0;
      IF_ID_STALL    = 1'b0;
      IF_ID_FLUSH    = 1'b0;
      ID_EX_BUBBLE   = 1'b0;
      DIV_START      = 1'b0;
      DIV_RESULT_SEL = 1'b0;
      if (!RESET) begin
         case (state_q)
            RUN: begin
               if (BRANCH_TAKEN) begin
                  IF_ID_FLUSH  = 1'b1;
                  ID_EX_BUBBLE = 1'b1;
               end else if (load_use) begin
                  PC_STALL     = 1'b1;
                  IF_ID_STALL  = 1'b1;
                  ID_EX_BUBBLE = 1'b1;
               end else if (ID_IS_DIV) begin
                  DIV_START    = 1'b1;
                  PC_STALL     = 1'b1;
                  IF_ID_STALL  = 1'b1;
                  ID_EX_BUBBLE = 1'b1;
               end
            end
            DIV_WAIT: begin
               PC_STALL     = 1'b1;
               IF_ID_STALL  = 1'b1;
               ID_EX_BUBBLE = 1'b1;
            end
            DIV_RELEASE: DIV_RESULT_SEL = 1'b1;
            default: ;
         endcase
      end
   end

   assign DIV_ERROR   = div_error_q;
   assign STALL_COUNT = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a vector table for RUN-state decode,
// plus hand-written sequences for divide latency, timeout and reset mid-divide.
module tb_hazard_stall_controller;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_uses_rs1, id_uses_rs2, id_is_div;
   logic        ex_mem_read, ex_write_en, branch_taken, div_done;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
   logic        div_start, div_result_sel, div_error;
   logic [31:0] stall_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       is_div;
      logic       mr;
      logic       we;
      logic [4:0] rd;
      logic       br;
      logic       e_stall;
      logic       e_flush;
      logic       e_bubble;
   } vec_t;

   vec_t tbl[11];

   hazard_stall_controller #(.DIV_TIMEOUT(40), .CNT_W(6)) dut (
      .CLK            (clk),
      .RESET          (reset),
      .ID_RS1_ADDR    (id_rs1_addr),
      .ID_RS2_ADDR    (id_rs2_addr),
      .ID_USES_RS1    (id_uses_rs1),
      .ID_USES_RS2    (id_uses_rs2),
      .ID_IS_DIV      (id_is_div),
      .EX_MEM_READ    (ex_mem_read),
      .EX_WRITE_EN    (ex_write_en),
      .EX_RD_ADDR     (ex_rd_addr),
      .BRANCH_TAKEN   (branch_taken),
      .DIV_DONE       (div_done),
      .PC_STALL       (pc_stall),
      .IF_ID_STALL    (if_id_stall),
      .IF_ID_FLUSH    (if_id_flush),
      .ID_EX_BUBBLE   (id_ex_bubble),
      .DIV_START      (div_start),
      .DIV_RESULT_SEL (div_result_sel),
      .DIV_ERROR      (div_error),
      .STALL_COUNT    (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idleInputs();
      id_rs1_addr  = 5'd0;
      id_rs2_addr  = 5'd0;
      id_uses_rs1  = 1'b0;
      id_uses_rs2  = 1'b0;
      id_is_div    = 1'b0;
      ex_mem_read  = 1'b0;
      ex_write_en  = 1'b0;
      ex_rd_addr   = 5'd0;
      branch_taken = 1'b0;
      div_done     = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      tick();
      id_rs1_addr  = v.rs1;
      id_rs2_addr  = v.rs2;
      id_uses_rs1  = v.u1;
      id_uses_rs2  = v.u2;
      id_is_div    = v.is_div;
      ex_mem_read  = v.mr;
      ex_write_en  = v.we;
      ex_rd_addr   = v.rd;
      branch_taken = v.br;
      div_done     = 1'b0;
      settle();
   endtask

   task automatic checkQuiet(input string nm);
      checkOutput({nm, "_stall"},  {31'd0, pc_stall | if_id_stall}, 32'd0);
      checkOutput({nm, "_flush"},  {31'd0, if_id_flush},  32'd0);
      checkOutput({nm, "_bubble"}, {31'd0, id_ex_bubble}, 32'd0);
      checkOutput({nm, "_start"},  {31'd0, div_start},    32'd0);
      checkOutput({nm, "_rsel"},   {31'd0, div_result_sel}, 32'd0);
   endtask

   task automatic doReset();
      tick();
      reset = 1'b1;
      idleInputs();
      settle();
      tick();
      reset = 1'b0;
      settle();
   endtask

   initial begin
      int exp_cnt;
      int starts;
      int stalls;
      reset = 1'b1;
      idleInputs();

      tbl[0]  = '{5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{5'd9, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{5'd9, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{5'd6, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset with a live load-use pattern: outputs must still be held low.
      tick();
      ex_mem_read = 1'b1; ex_write_en = 1'b1; ex_rd_addr = 5'd5;
      id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5; id_is_div = 1'b1;
      settle();
      checkQuiet("in_reset");
      tick();
      reset = 1'b0;
      idleInputs();
      settle();
      checkQuiet("after_reset");
      checkOutput("reset_count", stall_count, 32'd0);
      checkOutput("reset_error", {31'd0, div_error}, 32'd0);

      exp_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("v%0d_pc_stall", i), {31'd0, pc_stall}, {31'd0, tbl[i].e_stall});
         checkOutput($sformatf("v%0d_ifid_stall", i), {31'd0, if_id_stall}, {31'd0, tbl[i].e_stall});
         checkOutput($sformatf("v%0d_flush", i), {31'd0, if_id_flush}, {31'd0, tbl[i].e_flush});
         checkOutput($sformatf("v%0d_bubble", i), {31'd0, id_ex_bubble}, {31'd0, tbl[i].e_bubble});
         checkOutput($sformatf("v%0d_start", i), {31'd0, div_start}, 32'd0);
         checkOutput($sformatf("v%0d_rsel", i), {31'd0, div_result_sel}, 32'd0);
         if (tbl[i].e_stall) exp_cnt++;
      end
      tick();
      idleInputs();
      settle();
      checkQuiet("table_tail");
      checkOutput("table_count", stall_count, exp_cnt);

      // Divide with DIV_DONE on the 33rd wait cycle.
      doReset();
      starts = 0;
      stalls = 0;
      tick();
      id_is_div = 1'b1;
      settle();
      checkOutput("div_start_first", {31'd0, div_start}, 32'd1);
      starts += int'(div_start);
      stalls += int'(pc_stall);
      for (int w = 1; w <= 33; w++) begin
         tick();
         id_is_div = 1'b0;
         div_done  = (w == 33);
         settle();
         starts += int'(div_start);
         stalls += int'(pc_stall);
         checkOutput($sformatf("div_wait%0d_bubble", w), {31'd0, id_ex_bubble}, 32'd1);
      end
      tick();
      div_done = 1'b0;
      settle();
      checkOutput("div_release_rsel", {31'd0, div_result_sel}, 32'd1);
      checkOutput("div_release_stall", {31'd0, pc_stall}, 32'd0);
      checkOutput("div_start_count", starts, 32'd1);
      checkOutput("div_stall_cycles", stalls, 32'd34);
      checkOutput("div_stall_count", stall_count, 32'd34);
      tick();
      settle();
      checkQuiet("div_after");
      checkOutput("div_no_error", {31'd0, div_error}, 32'd0);

      // Minimum occupancy: DONE already high at start, back-to-back divide after release.
      tick();
      id_is_div = 1'b1; div_done = 1'b1;
      settle();
      checkOutput("min_start", {31'd0, div_start}, 32'd1);
      tick();
      id_is_div = 1'b0;
      settle();
      checkOutput("min_wait_stall", {31'd0, pc_stall}, 32'd1);
      tick();
      id_is_div = 1'b1; div_done = 1'b0;
      settle();
      checkOutput("min_release_rsel", {31'd0, div_result_sel}, 32'd1);
      checkOutput("min_release_start", {31'd0, div_start}, 32'd0);
      tick();
      settle();
      checkOutput("b2b_start", {31'd0, div_start}, 32'd1);
      tick();
      id_is_div = 1'b0; div_done = 1'b1;
      settle();
      tick();
      div_done = 1'b0;
      settle();
      checkOutput("b2b_release_rsel", {31'd0, div_result_sel}, 32'd1);

      // Timeout: DONE never arrives; 40 wait cycles then a forced release.
      doReset();
      tick();
      id_is_div = 1'b1;
      settle();
      stalls = 0;
      for (int w = 1; w <= 40; w++) begin
         tick();
         id_is_div = 1'b0;
         settle();
         stalls += int'(pc_stall);
         if (w == 40) checkOutput("to_err_before", {31'd0, div_error}, 32'd0);
      end
      checkOutput("to_wait_stalls", stalls, 32'd40);
      tick();
      settle();
      checkOutput("to_release_rsel", {31'd0, div_result_sel}, 32'd1);
      checkOutput("to_error_set", {31'd0, div_error}, 32'd1);
      checkOutput("to_count", stall_count, 32'd41);
      for (int k = 0; k < 3; k++) begin
         tick();
         settle();
      end
      checkQuiet("to_idle");
      checkOutput("to_error_sticky", {31'd0, div_error}, 32'd1);
      doReset();
      checkOutput("to_error_cleared", {31'd0, div_error}, 32'd0);

      // Reset asserted in the 5th wait cycle.
      tick();
      id_is_div = 1'b1;
      settle();
      for (int w = 1; w <= 4; w++) begin
         tick();
         id_is_div = 1'b0;
         settle();
      end
      tick();
      reset = 1'b1;
      settle();
      checkQuiet("mid_reset");
      tick();
      reset = 1'b0;
      settle();
      checkQuiet("post_mid_reset");
      checkOutput("post_mid_count", stall_count, 32'd0);
      tick();
      id_is_div = 1'b1;
      settle();
      checkOutput("fresh_start", {31'd0, div_start}, 32'd1);
      tick();
      id_is_div = 1'b0; div_done = 1'b1;
      settle();
      tick();
      div_done = 1'b0;
      settle();
      checkOutput("fresh_release_rsel", {31'd0, div_result_sel}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
